mips_muldiv_unit: RTL

//  Parametrised iterative multiply/divide unit with built-in HI/LO registers for the MIPS core.

---
 rtl/mips_muldiv_if.sv | 25 ++
 rtl/mips_muldiv_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_if.sv
// CPU <-> multiply/divide unit connection: operation request, MTHI/MTLO writes, HI/LO and busy.
interface mips_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hl_wdata;
  logic             busy;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, op_a, op_b, hi_we, lo_we, hl_wdata,
    input  busy, hi_out, lo_out
  );

  modport slave (
    input  start, op, op_a, op_b, hi_we, lo_we, hl_wdata,
    output busy, hi_out, lo_out
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operands are reduced to magnitudes up front; signs are re-applied in a single FIXUP cycle.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clk_enable,
  mips_muldiv_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div0_q, div0_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand capture: magnitudes for signed ops (op[0]=0), raw values for unsigned
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~bus.op[0] & bus.op_a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.op_b[WIDTH-1];
  assign a_mag = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag = b_neg ? -bus.op_b : bus.op_b;

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  assign mul_addend = acc_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, mul_addend};

  // Restoring-divide step: acc = {partial remainder, remaining dividend / quotient bits}
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  assign div_shift = acc_q[AW-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_rem   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];

  // Sign correction; a zero divisor leaves the remainder equal to |op_a|, so HI restores op_a
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  assign prod_fix = res_neg_q ? -acc_q : acc_q;
  assign quot_fix = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.hl_wdata;
        if (bus.lo_we) lo_d = bus.hl_wdata;
        if (bus.start) begin
          is_div_d  = bus.op[1];
          res_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          div0_d    = (bus.op_b == '0);
          cnt_d     = CW'(WIDTH - 1);
          busy_d    = 1'b1;
          state_d   = CALC;
          if (bus.op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
      end

      CALC: begin
        if (is_div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      FIXUP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : quot_fix;
        end else begin
          hi_d = prod_fix[AW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset wins over the global enable and aborts any op
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule
